frame_rx: RTL and testbench

FRAME_RX -- requirements
Module: frame_rx

---
 rtl/frame_rx_pkg.sv | 17 +
 rtl/frame_rx_sync2.sv | 41 ++++
 rtl/frame_rx.sv | 161 ++++++++++++++++
 tb/tb_frame_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// frame_rx_pkg
// Shared definitions for the serial frame receiver:
//   DATA_W_DEF : default number of payload bits per frame
//   state_t    : receiver FSM state encoding
// -----------------------------------------------------------------------------
package frame_rx_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/frame_rx_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk : sampling clock
//   rst : synchronous active-high reset, loads both flops with RST_VAL
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/frame_rx.sv
// -----------------------------------------------------------------------------
// frame_rx
// Strobe-driven serial frame receiver: start bit (0), DATA_W payload bits
// LSB first, one stop bit (1). Bits are sampled only on bit_en strobes from
// the synchronized line. Good payloads are offered on a valid/ready output
// register; a bad stop bit raises frame_err, and a good frame arriving while
// the output is still held raises overrun and is dropped.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle, waiting for a strobe that samples a low start bit
// DATA  | shifting in payload bits, one per strobe
// STOP  | next strobe samples the stop bit and finishes the frame
//
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   sin       : asynchronous serial line, idle high
//   bit_en    : one-cycle bit-sample strobe
//   out_ready : consumer accepts out_data this cycle
//   out_data  : last good frame payload
//   out_valid : out_data holds an unaccepted word
//   frame_err : one-cycle pulse on a bad stop bit
//   overrun   : one-cycle pulse when a good frame is dropped
// -----------------------------------------------------------------------------
module frame_rx
    import frame_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              bit_en,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              sin_s;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              frame_err_q;
    logic              frame_err_d;
    logic              overrun_q;
    logic              overrun_d;

    logic              stop_hit;
    logic              good_frame;
    logic              bad_frame;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (sin),
        .q   (sin_s)
    );

    // State register and all other flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state, bit counter and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sin_s) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    // Right shift in at the MSB: after DATA_W bits the first
                    // line bit has reached bit 0.
                    shift_d = {sin_s, shift_q[DATA_W-1:1]};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output holding register and status pulses.
    always_comb begin
        stop_hit   = (state_q == ST_STOP) && bit_en;
        good_frame = stop_hit && sin_s;
        bad_frame  = stop_hit && !sin_s;

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = bad_frame;
        overrun_d   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // An accept in the same cycle frees the holding register, so the
        // new payload can take its place without an overrun.
        if (good_frame) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_frame_rx
// Self-checking bench for frame_rx (DATA_W = 8). Frames are sent as line
// bits with a strobe every 4 clk cycles; a transaction-level model of the
// output register predicts out_data/out_valid and the pulse outputs.
// -----------------------------------------------------------------------------
module tb_frame_rx;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          sin;
    logic          bit_en;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          frame_err;
    logic          overrun;

    int n_chk;
    int n_pass;

    // Model of the consumer-visible output register.
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            exp_err_tot;
    int            exp_ovr_tot;
    int            mon_err_tot;
    int            mon_ovr_tot;

    frame_rx #(
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .bit_en    (bit_en),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Pulse totals seen on the outputs, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_err) mon_err_tot <= mon_err_tot + 1;
        if (overrun)   mon_ovr_tot <= mon_ovr_tot + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line bit: sin settles well before the strobe edge (4th edge).
    task automatic send_bit(input logic b);
        sin    = b;
        bit_en = 1'b0;
        tick();
        tick();
        tick();
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic stop, input logic rdy,
                              input string tag);
        logic e_err;
        logic e_ovr;
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            send_bit(data[i]);
        end
        sin    = stop;
        bit_en = 1'b0;
        tick();
        tick();
        tick();
        bit_en    = 1'b1;
        out_ready = rdy;
        // Nothing may react before the stop strobe edge.
        chk({tag, "_pre_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, "_pre_err"}, {31'd0, frame_err}, 32'd0);
        tick();
        bit_en    = 1'b0;
        out_ready = 1'b0;

        e_err = 1'b0;
        e_ovr = 1'b0;
        if (stop) begin
            if (!m_valid || rdy) begin
                m_data  = data;
                m_valid = 1'b1;
            end else begin
                e_ovr = 1'b1;
                exp_ovr_tot++;
            end
        end else begin
            e_err = 1'b1;
            exp_err_tot++;
            if (m_valid && rdy) m_valid = 1'b0;
        end

        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, m_data});
        chk({tag, "_err"}, {31'd0, frame_err}, {31'd0, e_err});
        chk({tag, "_ovr"}, {31'd0, overrun}, {31'd0, e_ovr});
        tick();
        chk({tag, "_err_1cyc"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_ovr_1cyc"}, {31'd0, overrun}, 32'd0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_valid   = 1'b0;
        chk({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    // One-cycle low pulse on the line between strobes while idle.
    task automatic glitch(input string tag);
        sin    = 1'b1;
        bit_en = 1'b0;
        tick();
        sin = 1'b0;
        tick();
        sin = 1'b1;
        tick();
        tick();
        tick();
        send_bit(1'b1);
        chk({tag, "_glitch_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, "_glitch_data"}, {24'd0, out_data}, {24'd0, m_data});
        chk({tag, "_glitch_err"}, mon_err_tot, exp_err_tot);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        m_valid     = 1'b0;
        m_data      = '0;
        exp_err_tot = 0;
        exp_ovr_tot = 0;
        mon_err_tot = 0;
        mon_ovr_tot = 0;
        sin         = 1'b1;
        bit_en      = 1'b0;
        out_ready   = 1'b0;
        rst         = 1'b1;
        tick();
        do_reset();

        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);

        glitch("idle");

        send_frame(8'h3C, 1'b0, 1'b0, "bad3c");
        chk("bad3c_data_zero", {24'd0, out_data}, 32'd0);

        send_frame(8'hA5, 1'b1, 1'b1, "a5");
        out_ready = 1'b1;
        drain("a5");

        send_frame(8'h3C, 1'b1, 1'b0, "ovr_a");
        send_frame(8'hC3, 1'b1, 1'b0, "ovr_b");
        chk("ovr_held", {24'd0, out_data}, 32'h3C);
        drain("ovr");

        send_frame(8'h3C, 1'b1, 1'b0, "rdy_a");
        send_frame(8'hC3, 1'b1, 1'b1, "rdy_b");
        chk("rdy_new", {24'd0, out_data}, 32'hC3);
        drain("rdy");

        // Reset in the middle of a frame: partial payload vanishes silently.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_reset();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {24'd0, out_data}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, "post_rst");
        chk("post_rst_err_tot", mon_err_tot, exp_err_tot);
        chk("post_rst_ovr_tot", mon_ovr_tot, exp_ovr_tot);
        drain("post_rst");

        for (int k = 0; k < 40; k++) begin
            logic [DW-1:0] d;
            logic          s;
            logic          r;
            d = DW'($urandom_range(255));
            s = ($urandom_range(9) != 0);
            r = 1'($urandom_range(1));
            send_frame(d, s, r, "rnd");
            if ($urandom_range(3) == 0) drain("rnd");
            if ($urandom_range(4) == 0) glitch("rnd");
        end

        chk("tot_err", mon_err_tot, exp_err_tot);
        chk("tot_ovr", mon_ovr_tot, exp_ovr_tot);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
